// File: rtl/sincos_angle_decoder_pkg.sv
// Package sincos_pkg: shared types and constants for the sine/cos angle decoder.
// Holds the CORDIC arctangent table, the controller state enum and the
// gain-compensation shift constants used when MAG_COMP_EN is defined.
package sincos_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROT  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Arctangent table is kept at 2**20 BAU per circle and rounded down to the
    // requested angle width, so any ANGLE_W below 20 gets a correctly rounded table.
    localparam int ATAN_FRAC_W = 20;

    // Shift amounts of x/2 + x/8 - x/64 - x/512 (about 0.6074, the inverse CORDIC gain).
    localparam int MAGC_SH0 = 1;
    localparam int MAGC_SH1 = 3;
    localparam int MAGC_SH2 = 6;
    localparam int MAGC_SH3 = 9;

    // round(atan(2**-i) * 2**20 / (2*pi)) for i = 0..11
    function automatic logic [31:0] atan_ref(input logic [3:0] i);
        logic [31:0] t;
        case (i)
            4'd0:    t = 32'd131072;
            4'd1:    t = 32'd77376;
            4'd2:    t = 32'd40884;
            4'd3:    t = 32'd20753;
            4'd4:    t = 32'd10417;
            4'd5:    t = 32'd5213;
            4'd6:    t = 32'd2607;
            4'd7:    t = 32'd1304;
            4'd8:    t = 32'd652;
            4'd9:    t = 32'd326;
            4'd10:   t = 32'd163;
            4'd11:   t = 32'd81;
            default: t = 32'd0;
        endcase
        return t;
    endfunction

    // Arctangent of step i in BAU for a circle of 2**aw units, rounded to nearest.
    function automatic logic [31:0] atan_bau(input logic [3:0] i, input int aw);
        logic [31:0] t;
        t = atan_ref(i) + (32'd1 << (ATAN_FRAC_W - aw - 1));
        return t >> (ATAN_FRAC_W - aw);
    endfunction

    // Multiply a non-negative magnitude by about 0.6074 with shifts and adds.
    function automatic logic signed [31:0] gain_comp(input logic signed [31:0] x);
        return (x >>> MAGC_SH0) + (x >>> MAGC_SH1) - (x >>> MAGC_SH2) - (x >>> MAGC_SH3);
    endfunction

endpackage

// File: rtl/sincos_angle_decoder_step.sv
// cordic_vec_step: one combinational CORDIC vectoring micro-rotation.
// Drives y toward zero; the rotation direction follows the sign of the incoming y,
// and both shifted terms use the pre-step x and y.
module cordic_vec_step
    import sincos_pkg::*;
#(
    parameter int W       = 11,
    parameter int ANGLE_W = 10
) (
    input  logic signed [W-1:0]       i_x,
    input  logic signed [W-1:0]       i_y,
    input  logic        [ANGLE_W-1:0] i_z,
    input  logic        [3:0]         i_step,
    output logic signed [W-1:0]       o_x,
    output logic signed [W-1:0]       o_y,
    output logic        [ANGLE_W-1:0] o_z
);

    logic signed [W-1:0]  w_xs;
    logic signed [W-1:0]  w_ys;
    logic [ANGLE_W-1:0]   w_atan;

    assign w_xs   = i_x >>> i_step;
    assign w_ys   = i_y >>> i_step;
    assign w_atan = ANGLE_W'(atan_bau(i_step, ANGLE_W));

    // Rotate clockwise when y is non-negative, counter-clockwise otherwise; z wraps naturally.
    always_comb begin
        o_x = i_x;
        o_y = i_y;
        o_z = i_z;
        if (!i_y[W-1]) begin
            o_x = i_x + w_ys;
            o_y = i_y - w_xs;
            o_z = i_z + w_atan;
        end else begin
            o_x = i_x - w_ys;
            o_y = i_y + w_xs;
            o_z = i_z - w_atan;
        end
    end

endmodule

// File: rtl/sincos_angle_decoder.sv
// sincos_angle_decoder: recovers phase angle and magnitude from a signed 8-bit
// (sine, cos) pair with an iterative CORDIC, one micro-rotation per clock.
// Optional build macro MAG_COMP_EN: removes the CORDIC gain from mag via a
// shift-add scale applied when the result is registered (angle unaffected).
module sincos_angle_decoder
    import sincos_pkg::*;
#(
    parameter int ITER    = 8,
    parameter int ANGLE_W = 10,
    parameter int MAG_W   = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         sine,
    input  logic [7:0]         cos,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ANGLE_W-1:0] angle,
    output logic [MAG_W-1:0]   mag
);

    // One guard bit above MAG_W holds 128*sqrt(2)*1.647 and the +128 from negating -128.
    localparam int W = MAG_W + 1;

    state_t               r_state;
    state_t               w_next;
    logic [3:0]           r_step;
    logic signed [W-1:0]  r_x;
    logic signed [W-1:0]  r_y;
    logic [ANGLE_W-1:0]   r_z;
    logic                 r_zero;
    logic [ANGLE_W-1:0]   r_angle;
    logic [MAG_W-1:0]     r_mag;

    logic signed [W-1:0]  w_sine_ext;
    logic signed [W-1:0]  w_cos_ext;
    logic signed [W-1:0]  w_x0;
    logic signed [W-1:0]  w_y0;
    logic [ANGLE_W-1:0]   w_z0;
    logic signed [W-1:0]  w_xn;
    logic signed [W-1:0]  w_yn;
    logic [ANGLE_W-1:0]   w_zn;
    logic                 w_accept;
    logic                 w_last;

    // Final x to output magnitude; x is never negative after vectoring.
    function automatic logic [MAG_W-1:0] mag_out(input logic signed [W-1:0] x);
        logic signed [31:0] v;
`ifdef MAG_COMP_EN
        v = gain_comp(32'(x));
`else
        v = 32'(x);
`endif
        return v[MAG_W-1:0];
    endfunction

    // Left half-plane inputs are rotated by 180 degrees so the CORDIC only sees x >= 0.
    assign w_sine_ext = {{(W-8){sine[7]}}, sine};
    assign w_cos_ext  = {{(W-8){cos[7]}}, cos};
    assign w_x0       = cos[7] ? -w_cos_ext  : w_cos_ext;
    assign w_y0       = cos[7] ? -w_sine_ext : w_sine_ext;
    assign w_z0       = cos[7] ? {1'b1, {(ANGLE_W-1){1'b0}}} : '0;

    assign in_ready   = reset && (r_state == IDLE);
    assign out_valid  = (r_state == DONE);
    assign angle      = r_angle;
    assign mag        = r_mag;
    assign w_accept   = in_valid && in_ready;
    assign w_last     = (r_step == 4'(ITER - 1));

    cordic_vec_step #(
        .W       (W),
        .ANGLE_W (ANGLE_W)
    ) u_step (
        .i_x    (r_x),
        .i_y    (r_y),
        .i_z    (r_z),
        .i_step (r_step),
        .o_x    (w_xn),
        .o_y    (w_yn),
        .o_z    (w_zn)
    );

    // Controller state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic: accept in IDLE, iterate in ROT, hold the result in DONE until taken.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept)  w_next = ROT;
            ROT:     if (w_last)    w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Working registers: load the pre-rotated sample at the handshake, then one step per clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_x    <= '0;
            r_y    <= '0;
            r_z    <= '0;
            r_step <= '0;
            r_zero <= 1'b0;
        end else if (r_state == IDLE) begin
            if (w_accept) begin
                r_x    <= w_x0;
                r_y    <= w_y0;
                r_z    <= w_z0;
                r_step <= '0;
                r_zero <= (sine == 8'd0) && (cos == 8'd0);
            end
        end else if (r_state == ROT) begin
            r_x    <= w_xn;
            r_y    <= w_yn;
            r_z    <= w_zn;
            r_step <= r_step + 4'd1;
        end
    end

    // Result registers load only on entry to DONE and hold until the next result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_angle <= '0;
            r_mag   <= '0;
        end else if ((r_state == ROT) && w_last) begin
            r_angle <= r_zero ? '0 : w_zn;
            r_mag   <= r_zero ? '0 : mag_out(w_xn);
        end
    end

endmodule

// File: tb/tb_sincos_angle_decoder.sv
// Testbench for sincos_angle_decoder (ITER=8, ANGLE_W=10, MAG_W=10).
module tb_sincos_angle_decoder;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] tb_sine;
    logic [7:0] tb_cos;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] angle;
    logic [9:0] mag;

    int n_checks = 0;
    int n_fail   = 0;

    sincos_angle_decoder #(
        .ITER    (8),
        .ANGLE_W (10),
        .MAG_W   (10)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sine      (tb_sine),
        .cos       (tb_cos),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .angle     (angle),
        .mag       (mag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    typedef struct {
        int s;
        int c;
        int ang;
        int mraw;
        int mcomp;
        int mtol;
    } vec_t;

    task automatic check_eq(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Angle comparison modulo 1024.
    task automatic check_ang(input string name, input int act, input int exp, input int tol);
        int d;
        n_checks++;
        d = (act - exp) & 1023;
        if (d > 512) d = 1024 - d;
        if (d > tol) begin
            n_fail++;
            $display("FAIL %s: got angle %0d, expected %0d +-%0d", name, act, exp, tol);
        end
    endtask

    task automatic check_tol(input string name, input int act, input int exp, input int tol);
        n_checks++;
        if (act < exp - tol || act > exp + tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d +-%0d", name, act, exp, tol);
        end
    endtask

    // Present one sample; returns just after the handshake edge. Inputs are scrambled after.
    task automatic handshake(input int s, input int c);
        int wait_cyc;
        @(negedge clk);
        wait_cyc = 0;
        while (!in_ready && wait_cyc < 40) begin
            @(negedge clk);
            wait_cyc++;
        end
        tb_sine  = 8'(s);
        tb_cos   = 8'(c);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        tb_sine  = 8'(s) ^ 8'h5A;
        tb_cos   = 8'(c) ^ 8'hA5;
    endtask

    // Count edges from the handshake until out_valid is seen (bounded).
    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic accept();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    vec_t tbl[7];
    int   lat;
    int   exp_mag;
    int   a_hold;
    int   m_hold;
    int   prev_a;
    int   saw_valid;
    real  ph;
    real  rs;
    real  rc;

    initial begin
        tbl[0] = '{s:    0, c:  120, ang:   0, mraw: 198, mcomp: 120, mtol: 2};
        tbl[1] = '{s:  120, c:    0, ang: 256, mraw: 198, mcomp: 120, mtol: 2};
        tbl[2] = '{s:    0, c: -120, ang: 512, mraw: 198, mcomp: 120, mtol: 2};
        tbl[3] = '{s: -120, c:    0, ang: 768, mraw: 198, mcomp: 120, mtol: 2};
        tbl[4] = '{s: -128, c: -128, ang: 640, mraw: 300, mcomp: 181, mtol: 2};
        tbl[5] = '{s:    0, c:    0, ang:   0, mraw:   0, mcomp:   0, mtol: 0};
        tbl[6] = '{s:   90, c:   90, ang: 128, mraw: 210, mcomp: 127, mtol: 4};

        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tb_sine   = 8'd0;
        tb_cos    = 8'd0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("in_ready_in_reset", in_ready, 0);
        check_eq("out_valid_in_reset", out_valid, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_eq("in_ready_after_reset", in_ready, 1);
        check_eq("out_valid_after_reset", out_valid, 0);
        check_eq("angle_after_reset", angle, 0);
        check_eq("mag_after_reset", mag, 0);

        // Out_ready while idle is ignored
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq("idle_out_ready_ignored", {in_ready, out_valid}, 2'b10);

        // Table-driven vectors
        for (int k = 0; k < 7; k++) begin
            handshake(tbl[k].s, tbl[k].c);
            wait_result(lat);
            check_eq($sformatf("latency[%0d]", k), lat, 8);
`ifdef MAG_COMP_EN
            exp_mag = tbl[k].mcomp;
`else
            exp_mag = tbl[k].mraw;
`endif
            check_ang($sformatf("angle[%0d]", k), int'(angle), tbl[k].ang, 2);
            check_tol($sformatf("mag[%0d]", k), int'(mag), exp_mag, tbl[k].mtol);
            check_eq($sformatf("in_ready_done[%0d]", k), in_ready, 0);
            accept();
            check_eq($sformatf("back_to_idle[%0d]", k), {in_ready, out_valid}, 2'b10);
        end

        // Hold in DONE with out_ready low for 5 cycles
        handshake(120, 0);
        wait_result(lat);
        check_eq("hold_latency", lat, 8);
        a_hold = int'(angle);
        m_hold = int'(mag);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check_eq($sformatf("hold_outputs[%0d]", k),
                     {out_valid, in_ready, angle, mag}, {1'b1, 1'b0, 10'(a_hold), 10'(m_hold)});
        end
        accept();
        check_eq("hold_release_in_ready", in_ready, 1);
        check_eq("hold_release_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        check_eq("idle_holds_angle", angle, 10'(a_hold));

        // Reset during ROT step 3 aborts without a result
        handshake(0, -120);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_eq("abort_in_ready", in_ready, 0);
        check_eq("abort_angle_cleared", angle, 0);
        check_eq("abort_mag_cleared", mag, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        saw_valid = 0;
        for (int k = 0; k < 14; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) saw_valid = 1;
        end
        check_eq("abort_no_out_valid", saw_valid, 0);
        handshake(-120, 0);
        wait_result(lat);
        check_eq("post_abort_latency", lat, 8);
        check_ang("post_abort_angle", int'(angle), 768, 2);
        accept();

        // Oscillator sequence: phase advances 16 BAU per sample
        prev_a = 0;
        for (int k = 0; k < 64; k++) begin
            ph = 2.0 * 3.14159265358979 * real'(16 * k) / 1024.0;
            rs = 100.0 * $sin(ph);
            rc = 100.0 * $cos(ph);
            handshake($rtoi(rs + ((rs >= 0.0) ? 0.5 : -0.5)),
                      $rtoi(rc + ((rc >= 0.0) ? 0.5 : -0.5)));
            wait_result(lat);
            if (k == 0) begin
                check_ang("osc_angle[0]", int'(angle), 0, 2);
            end else begin
                check_ang($sformatf("osc_step[%0d]", k), (int'(angle) - prev_a) & 1023, 16, 4);
            end
            prev_a = int'(angle);
            accept();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
